// File: rtl/pipe_pkg.sv
// Shared definitions for the handshaked pipeline registers (EX/MEM now, IF/ID and ID/EX later).
// The state value doubles as the number of entries held.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_e;

    localparam int CTRL_W_DEF = 12;

    // All-zero control bundle is decoded downstream as a bubble.
    localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

    function automatic logic [1:0] state_occupancy(input pipe_state_e s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            EMPTY:   occ = 2'd0;
            FULL:    occ = 2'd1;
            SKID:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// One pipeline payload entry (FU result, store data, PC+4, control).
// Clear has priority over load so an emptied entry always reads back as zero.
module pipe_payload_reg #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 12
) (
    input  logic              clk,
    input  logic              clr_i,
    input  logic              ld_i,
    input  logic [WIDTH-1:0]  fu_i,
    input  logic [WIDTH-1:0]  ram_data_i,
    input  logic [WIDTH-1:0]  pcplus_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic [WIDTH-1:0]  fu_o,
    output logic [WIDTH-1:0]  ram_data_o,
    output logic [WIDTH-1:0]  pcplus_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    always_ff @(posedge clk) begin
        if (clr_i) begin
            fu_o       <= '0;
            ram_data_o <= '0;
            pcplus_o   <= '0;
            ctrl_o     <= '0;
        end else if (ld_i) begin
            fu_o       <= fu_i;
            ram_data_o <= ram_data_i;
            pcplus_o   <= pcplus_i;
            ctrl_o     <= ctrl_i;
        end
    end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with valid/ready handshake, flush and an optional 2-entry skid buffer.
// Outputs always come from the main entry; the skid entry only refills main.
module ex_mem_pipe_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int CTRL_W  = CTRL_W_DEF,
    parameter int SKID_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  fu_i,
    input  logic [WIDTH-1:0]  ram_data_i,
    input  logic [WIDTH-1:0]  pcplus_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  fu_o,
    output logic [WIDTH-1:0]  ram_data_o,
    output logic [WIDTH-1:0]  pcplus_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [1:0]        occupancy
);

    pipe_state_e state_q, state_d;

    logic push, pop;
    logic main_clr, main_ld, main_from_skid;
    logic skid_clr, skid_ld;

    logic [WIDTH-1:0]  main_fu_d, main_rd_d, main_pc_d;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [WIDTH-1:0]  main_fu_q, main_rd_q, main_pc_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [WIDTH-1:0]  skid_fu_q, skid_rd_q, skid_pc_q;
    logic [CTRL_W-1:0] skid_ctrl_q;

    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        main_clr       = 1'b0;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_clr       = 1'b0;
        skid_ld        = 1'b0;
        if (reset || flush) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        main_ld = 1'b1;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (push && pop) begin
                        main_ld = 1'b1;
                    end else if (push && (SKID_EN != 0)) begin
                        // MEM is stalled: park the new bundle behind the held one.
                        skid_ld = 1'b1;
                        state_d = SKID;
                    end else if (pop) begin
                        main_clr = 1'b1;
                        state_d  = EMPTY;
                    end
                end
                SKID: begin
                    if (pop) begin
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                        state_d        = FULL;
                    end
                end
                default: begin
                    state_d  = EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        main_fu_d   = fu_i;
        main_rd_d   = ram_data_i;
        main_pc_d   = pcplus_i;
        main_ctrl_d = ctrl_i;
        if (main_from_skid) begin
            main_fu_d   = skid_fu_q;
            main_rd_d   = skid_rd_q;
            main_pc_d   = skid_pc_q;
            main_ctrl_d = skid_ctrl_q;
        end
    end

    pipe_payload_reg #(
        .WIDTH  (WIDTH),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk        (clk),
        .clr_i      (main_clr),
        .ld_i       (main_ld),
        .fu_i       (main_fu_d),
        .ram_data_i (main_rd_d),
        .pcplus_i   (main_pc_d),
        .ctrl_i     (main_ctrl_d),
        .fu_o       (main_fu_q),
        .ram_data_o (main_rd_q),
        .pcplus_o   (main_pc_q),
        .ctrl_o     (main_ctrl_q)
    );

    generate
        if (SKID_EN != 0) begin : g_skid
            logic in_ready_q;

            pipe_payload_reg #(
                .WIDTH  (WIDTH),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .clk        (clk),
                .clr_i      (skid_clr),
                .ld_i       (skid_ld),
                .fu_i       (fu_i),
                .ram_data_i (ram_data_i),
                .pcplus_i   (pcplus_i),
                .ctrl_i     (ctrl_i),
                .fu_o       (skid_fu_q),
                .ram_data_o (skid_rd_q),
                .pcplus_o   (skid_pc_q),
                .ctrl_o     (skid_ctrl_q)
            );

            // Registered ready: low exactly while both entries are occupied.
            always_ff @(posedge clk) begin
                if (reset) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_d != SKID);
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_noskid
            logic unused_skid_ctl;

            assign unused_skid_ctl = skid_clr ^ skid_ld;
            assign skid_fu_q       = '0;
            assign skid_rd_q       = '0;
            assign skid_pc_q       = '0;
            assign skid_ctrl_q     = '0;
            assign in_ready        = out_ready | ~out_valid;
        end
    endgenerate

    assign fu_o       = main_fu_q;
    assign ram_data_o = main_rd_q;
    assign pcplus_o   = main_pc_q;
    assign ctrl_o     = out_valid ? main_ctrl_q : CTRL_W'(CTRL_NOP);
    assign occupancy  = state_occupancy(state_q);

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: both SKID_EN variants driven by the same inputs, each checked
// against a bounded-FIFO model, plus a directed vector table and hand-written corner sequences.
module tb_ex_mem_pipe_reg;

    localparam int W  = 32;
    localparam int CW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, flush, in_valid, out_ready;
    logic [W-1:0]  fu_i, rd_i, pc_i;
    logic [CW-1:0] ctrl_i;

    logic          ir1, ov1, ir0, ov0;
    logic [W-1:0]  fu1, rd1, pc1, fu0, rd0, pc0;
    logic [CW-1:0] ct1, ct0;
    logic [1:0]    occ1, occ0;

    ex_mem_pipe_reg #(.WIDTH(W), .CTRL_W(CW), .SKID_EN(1)) dut_skid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(ir1),
        .fu_i(fu_i), .ram_data_i(rd_i), .pcplus_i(pc_i), .ctrl_i(ctrl_i),
        .out_valid(ov1), .out_ready(out_ready),
        .fu_o(fu1), .ram_data_o(rd1), .pcplus_o(pc1), .ctrl_o(ct1),
        .occupancy(occ1)
    );

    ex_mem_pipe_reg #(.WIDTH(W), .CTRL_W(CW), .SKID_EN(0)) dut_noskid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(ir0),
        .fu_i(fu_i), .ram_data_i(rd_i), .pcplus_i(pc_i), .ctrl_i(ctrl_i),
        .out_valid(ov0), .out_ready(out_ready),
        .fu_o(fu0), .ram_data_o(rd0), .pcplus_o(pc0), .ctrl_o(ct0),
        .occupancy(occ0)
    );

    typedef struct {
        logic [W-1:0]  fu;
        logic [W-1:0]  rd;
        logic [W-1:0]  pc;
        logic [CW-1:0] ct;
    } payload_t;

    // Reference: a FIFO of capacity 2 (skid) or 1 (no skid); front entry is what MEM sees.
    payload_t q1[$];
    payload_t q0[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_dut(input string tag, input int size, input payload_t front,
                           input logic ov, input logic [1:0] occ, input logic [W-1:0] fu,
                           input logic [W-1:0] rd, input logic [W-1:0] pc, input logic [CW-1:0] ct);
        payload_t e;
        e = '{fu: '0, rd: '0, pc: '0, ct: '0};
        if (size != 0) e = front;
        chk({tag, " out_valid"}, 32'(ov), 32'(size != 0));
        chk({tag, " occupancy"}, 32'(occ), 32'(size));
        chk({tag, " fu_o"}, fu, e.fu);
        chk({tag, " ram_data_o"}, rd, e.rd);
        chk({tag, " pcplus_o"}, pc, e.pc);
        chk({tag, " ctrl_o"}, 32'(ct), 32'(e.ct));
    endtask

    // One clock of stimulus; checks ready before the edge and all outputs after it.
    task automatic step(input bit r, input bit f, input bit iv, input bit orr,
                        input logic [W-1:0] fu, input logic [CW-1:0] ct);
        bit exp_ir1, exp_ir0, push1, push0, pop1, pop0;
        payload_t p, f1, f0;
        reset     = r;
        flush     = f;
        in_valid  = iv;
        out_ready = orr;
        fu_i      = fu;
        rd_i      = $urandom;
        pc_i      = $urandom;
        ctrl_i    = ct;
        #1;
        exp_ir1 = (q1.size() < 2);
        exp_ir0 = (q0.size() == 0) || orr;
        chk("skid in_ready", 32'(ir1), 32'(exp_ir1));
        chk("noskid in_ready", 32'(ir0), 32'(exp_ir0));
        push1 = iv && exp_ir1;
        push0 = iv && exp_ir0;
        pop1  = (q1.size() != 0) && orr;
        pop0  = (q0.size() != 0) && orr;
        p = '{fu: fu_i, rd: rd_i, pc: pc_i, ct: ctrl_i};
        @(posedge clk);
        #1;
        if (r || f) begin
            q1.delete();
            q0.delete();
        end else begin
            if (pop1)  void'(q1.pop_front());
            if (push1) q1.push_back(p);
            if (pop0)  void'(q0.pop_front());
            if (push0) q0.push_back(p);
        end
        f1 = '{fu: '0, rd: '0, pc: '0, ct: '0};
        f0 = f1;
        if (q1.size() != 0) f1 = q1[0];
        if (q0.size() != 0) f0 = q0[0];
        chk_dut("skid", q1.size(), f1, ov1, occ1, fu1, rd1, pc1, ct1);
        chk_dut("noskid", q0.size(), f0, ov0, occ0, fu0, rd0, pc0, ct0);
    endtask

    typedef struct {
        bit            r, f, iv, orr;
        logic [W-1:0]  fu;
        logic [CW-1:0] ct;
        bit            ev;
        logic [W-1:0]  efu;
        logic [1:0]    eocc;
        bit            erdy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit f, bit iv, bit orr, logic [W-1:0] fu,
                                bit ev, logic [W-1:0] efu, logic [1:0] eocc, bit erdy);
        vec_t v;
        v.r = r; v.f = f; v.iv = iv; v.orr = orr; v.fu = fu; v.ct = 12'h0A5 ^ fu[11:0];
        v.ev = ev; v.efu = efu; v.eocc = eocc; v.erdy = erdy;
        return v;
    endfunction

    initial begin
        logic [W-1:0]  rfu;
        logic [CW-1:0] rct;
        bit r, f, iv, orr;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        fu_i = '0; rd_i = '0; pc_i = '0; ctrl_i = '0;
        @(posedge clk);
        #1;

        // Expected outputs of the skid variant after each edge.
        tbl.push_back(mk(1, 0, 1, 1, 32'h77, 0, 32'h0, 2'd0, 1));
        tbl.push_back(mk(1, 0, 1, 1, 32'h77, 0, 32'h0, 2'd0, 1));
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(0, 0, 1, 1, 32'(k), 1, 32'(k), 2'd1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0, 0, 32'h0, 2'd0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 32'hA, 1, 32'hA, 2'd1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 32'hB, 1, 32'hA, 2'd2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0, 1, 32'hA, 2'd2, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0, 1, 32'hB, 2'd1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0, 0, 32'h0, 2'd0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 32'hA, 1, 32'hA, 2'd1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 32'hB, 1, 32'hA, 2'd2, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'hC, 0, 32'h0, 2'd0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0, 0, 32'h0, 2'd0, 1));

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].orr, tbl[i].fu, tbl[i].ct);
            chk($sformatf("vec%0d out_valid", i), 32'(ov1), 32'(tbl[i].ev));
            chk($sformatf("vec%0d fu_o", i), fu1, tbl[i].efu);
            chk($sformatf("vec%0d occupancy", i), 32'(occ1), 32'(tbl[i].eocc));
            chk($sformatf("vec%0d in_ready", i), 32'(ir1), 32'(tbl[i].erdy));
        end

        // Stall: held bundle must not move while MEM withholds ready, despite noisy input data.
        step(0, 0, 1, 1, 32'hDEADBEEF, 12'hFFF);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 0, $urandom, 12'($urandom));
            chk($sformatf("stall%0d skid fu_o", k), fu1, 32'hDEADBEEF);
            chk($sformatf("stall%0d skid ctrl_o", k), 32'(ct1), 32'hFFF);
            chk($sformatf("stall%0d noskid fu_o", k), fu0, 32'hDEADBEEF);
            chk($sformatf("stall%0d noskid ctrl_o", k), 32'(ct0), 32'hFFF);
        end

        // No-skid variant: ready follows out_ready combinationally while full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        #1;
        chk("noskid ready drops with out_ready", 32'(ir0), 32'h0);
        out_ready = 1'b1;
        #1;
        chk("noskid ready rises with out_ready", 32'(ir0), 32'h1);
        step(0, 0, 1, 0, 32'h99, 12'h099);
        step(0, 0, 1, 1, 32'h5, 12'h005);
        chk("noskid reload fu_o", fu0, 32'h5);
        chk("noskid reload out_valid", 32'(ov0), 32'h1);

        // Randomised traffic against the FIFO model.
        step(1, 0, 0, 0, 32'h0, 12'h0);
        for (int k = 0; k < 3000; k++) begin
            r   = ($urandom_range(0, 199) == 0);
            f   = ($urandom_range(0, 99) < 5);
            iv  = ($urandom_range(0, 99) < 65);
            orr = ($urandom_range(0, 99) < 70);
            rfu = $urandom;
            rct = 12'($urandom);
            step(r, f, iv, orr, rfu, rct);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
